// File: rtl/rd_subtractor_pipe.sv
// Five-stage registered Kogge-Stone subtractor: diff = a - b - bin, computed as a + ~b + ~bin.
// Valid/ready on both sides; a single global stall freezes every stage, bubbles included.
module rd_subtractor_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] diff,
    output logic        bout,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int unsigned W  = 16;
    localparam int unsigned NS = 4;

    // One doubling level of group generate at distance d
    function automatic logic [W-1:0] ks_g(input logic [W-1:0] gg,
                                          input logic [W-1:0] pp,
                                          input int           d);
        logic [W-1:0] r;
        r = gg;
        for (int i = d; i < int'(W); i++) begin
            r[i] = gg[i] | (pp[i] & gg[i-d]);
        end
        return r;
    endfunction

    // One doubling level of group propagate at distance d
    function automatic logic [W-1:0] ks_p(input logic [W-1:0] pp,
                                          input int           d);
        logic [W-1:0] r;
        r = pp;
        for (int i = d; i < int'(W); i++) begin
            r[i] = pp[i] & pp[i-d];
        end
        return r;
    endfunction

    // Stage registers S0..S3; S4 is the output register set
    logic [NS-1:0]        sv;
    logic [NS-1:0]        sc0;
    logic [NS-1:0][W-1:0] grp_g;
    logic [NS-1:0][W-1:0] grp_p;
    logic [NS-1:0][W-1:0] bit_p;

    logic [W-1:0] g_in;
    logic [W-1:0] p_in;
    logic [W-1:0] g1;
    logic [W-1:0] p1;
    logic [W-1:0] g2;
    logic [W-1:0] p2;
    logic [W-1:0] g3;
    logic [W-1:0] p3;
    logic [W-1:0] g4;
    logic [W:0]   carry;
    logic         stall;

    // Bitwise generate/propagate with the inverted borrow folded into bit 0
    always_comb begin
        p_in    = a ^ ~b;
        g_in    = a & ~b;
        g_in[0] = g_in[0] | (p_in[0] & ~bin);
    end

    assign g1 = ks_g(grp_g[0], grp_p[0], 1);
    assign p1 = ks_p(grp_p[0], 1);
    assign g2 = ks_g(grp_g[1], grp_p[1], 2);
    assign p2 = ks_p(grp_p[1], 2);
    assign g3 = ks_g(grp_g[2], grp_p[2], 4);
    assign p3 = ks_p(grp_p[2], 4);
    assign g4 = ks_g(grp_g[3], grp_p[3], 8);

    // carry[i+1] is the group generate over bits i..0; carry[0] is the inverted borrow
    assign carry = {g4, sc0[NS-1]};

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign busy     = (|sv) | out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv        <= '0;
            sc0       <= '0;
            grp_g     <= '0;
            grp_p     <= '0;
            bit_p     <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            sv        <= {sv[NS-2:0], in_valid};
            sc0       <= {sc0[NS-2:0], ~bin};
            bit_p     <= {bit_p[NS-2:0], p_in};
            grp_g[0]  <= g_in;
            grp_g[1]  <= g1;
            grp_g[2]  <= g2;
            grp_g[3]  <= g3;
            grp_p[0]  <= p_in;
            grp_p[1]  <= p1;
            grp_p[2]  <= p2;
            grp_p[3]  <= p3;
            out_valid <= sv[NS-1];
            diff      <= bit_p[NS-1] ^ carry[W-1:0];
            bout      <= ~carry[W];
            ovf       <= carry[W] ^ carry[W-1];
        end
    end

endmodule

// File: tb/tb_rd_subtractor_pipe.sv
// Scoreboard bench for rd_subtractor_pipe: expected {ovf,bout,diff} queued on accept,
// popped and compared on consume; directed phases followed by a random stream.
module tb_rd_subtractor_pipe;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    rd_subtractor_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] sb[$];
    logic [17:0] cur_exp;
    logic [17:0] held;
    logic [17:0] got;
    logic        was_stall = 1'b0;
    logic        last_acc  = 1'b0;
    int          n_stall   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: {ovf, bout, diff} from wide unsigned and signed arithmetic
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0]        u;
        logic signed [17:0] s;
        logic               o;
        u = {1'b0, x} - {1'b0, y} - {16'd0, c};
        s = $signed({x[15], x[15], x}) - $signed({y[15], y[15], y}) - $signed({17'd0, c});
        o = (s > 18'sd32767) || (s < -18'sd32768);
        return {o, u[16], u[15:0]};
    endfunction

    // One clock: sample mid-cycle, score transfers, then return 1 time unit after the edge
    task automatic step();
        @(negedge clk);
        got = {ovf, bout, diff};
        if (was_stall) chk("held_outputs", 32'(got), 32'(held));
        chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (out_valid && !out_ready) n_stall++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
            else chk("result", 32'(got), 32'(sb.pop_front()));
        end
        last_acc = in_valid && in_ready;
        if (last_acc) sb.push_back(cur_exp);
        was_stall = out_valid && !out_ready;
        held      = got;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic c, input logic [17:0] e);
        int n;
        a = x; b = y; bin = c; cur_exp = e; in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        chk("accept_timeout", 32'(last_acc), 32'd1);
    endtask

    task automatic single(input logic [15:0] x, input logic [15:0] y, input logic c, input logic [17:0] e);
        int n;
        out_ready = 1'b1;
        drive(x, y, c, e);
        in_valid = 1'b0;
        chk("busy_inflight", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        chk("single_diff", 32'(diff), 32'(e[15:0]));
        step();
        chk("valid_pulse", 32'(out_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        step();
        chk("busy_drained", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int idx;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0; cur_exp = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_outputs", 32'({ovf, bout, diff}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op with latency and one-cycle valid pulse
        single(16'd65535, 16'd56, 1'b0, {1'b0, 1'b0, 16'd65479});

        // Back-to-back stream, results on 4 consecutive cycles
        drive(16'd0,    16'd0,   1'b0, {1'b0, 1'b0, 16'd0});
        drive(16'd600,  16'd0,   1'b0, {1'b0, 1'b0, 16'd600});
        drive(16'd600,  16'd807, 1'b0, {1'b0, 1'b1, 16'd65329});
        drive(16'd1025, 16'd807, 1'b1, {1'b0, 1'b0, 16'd217});
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            chk("stream_consecutive", 32'(out_valid), 32'd1);
            step();
        end
        chk("stream_end", 32'(out_valid), 32'd0);

        // Boundary arithmetic
        drive(16'h0000, 16'h0000, 1'b1, {1'b0, 1'b1, 16'hFFFF});
        drive(16'h8000, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h7FFF});
        drive(16'h7FFF, 16'hFFFF, 1'b0, {1'b1, 1'b1, 16'h8000});
        drive(16'hFFFF, 16'hFFFF, 1'b0, {1'b0, 1'b0, 16'h0000});
        drain();

        // Backpressure: out_ready low for 3 cycles while the pipe is full
        idx = 0; cyc = 0; n_stall = 0;
        a = 16'd123; b = 16'd0; bin = 1'b0; cur_exp = model(a, b, bin);
        while (idx < 6 && cyc < 40) begin
            in_valid  = 1'b1;
            out_ready = !(cyc >= 5 && cyc <= 7);
            step();
            if (last_acc) begin
                idx++;
                a = 16'(1000 * idx + 123); b = 16'(7777 * idx); bin = idx[0];
                cur_exp = model(a, b, bin);
            end
            cyc++;
        end
        chk("bp_accepted", 32'(idx), 32'd6);
        drain();
        chk("bp_stall_cycles", 32'(n_stall), 32'd3);

        // Asynchronous reset with three ops in flight
        out_ready = 1'b1;
        drive(16'd5000, 16'd17, 1'b0, model(16'd5000, 16'd17, 1'b0));
        drive(16'd9, 16'd900, 1'b1, model(16'd9, 16'd900, 1'b1));
        drive(16'd77, 16'd77, 1'b0, model(16'd77, 16'd77, 1'b0));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_outputs", 32'({ovf, bout, diff}), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        was_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) step();
        chk("arst_no_stale", 32'(busy), 32'd0);
        single(16'd1025, 16'd807, 1'b1, {1'b0, 1'b0, 16'd217});

        // Random traffic against the model
        idx = 0; cyc = 0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); cur_exp = model(a, b, bin);
        while (idx < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (last_acc) begin
                idx++;
                a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
                cur_exp = model(a, b, bin);
            end
            cyc++;
        end
        chk("rand_accepted", 32'(idx), 32'd10000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
